// File: rtl/mult_cmd_driver.sv
// Command-to-handshake front end for the multiplier: builds operand parity,
// runs req/ack/result_rdy with the multiplier and returns one response per command.
package mult_pkg;
    typedef enum logic [2:0] {
        RST_OP            = 3'b000,
        VALID_A_B         = 3'b001,
        INVALID_A_B       = 3'b010,
        VALID_A_INVALID_B = 3'b011,
        VALID_B_INVALID_A = 3'b100
    } operation_t;
endpackage

module mult_cmd_driver
    import mult_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 255,
    parameter int RST_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    output logic                mult_rst_n,
    output logic                req,
    output logic [DATA_W-1:0]   arg_a,
    output logic [DATA_W-1:0]   arg_b,
    output logic                arg_a_parity,
    output logic                arg_b_parity,
    input  logic                ack,
    input  logic [2*DATA_W-1:0] result,
    input  logic                result_parity,
    input  logic                result_rdy,
    input  logic                arg_parity_error,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2:0]          rsp_op,
    output logic [2*DATA_W-1:0] rsp_result,
    output logic                rsp_arg_err,
    output logic                rsp_arg_err_mismatch,
    output logic                rsp_res_par_err,
    output logic                rsp_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int RC_W  = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, MRST, REQ, WAIT_RES, RSP} state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic             r_exp_err;
    logic [CNT_W-1:0] r_cnt;
    logic [RC_W-1:0]  r_rst_cnt;

    logic w_inv_a;
    logic w_inv_b;
    logic w_res_par_err;

    // Opcodes 101-111 invert nothing, so they behave exactly like VALID_A_B.
    assign w_inv_a       = (cmd_op == INVALID_A_B) || (cmd_op == VALID_B_INVALID_A);
    assign w_inv_b       = (cmd_op == INVALID_A_B) || (cmd_op == VALID_A_INVALID_B);
    assign w_res_par_err = result_parity ^ (^result);
    assign cmd_ready     = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state              <= IDLE;
            r_op                 <= '0;
            r_exp_err            <= 1'b0;
            r_cnt                <= '0;
            r_rst_cnt            <= '0;
            mult_rst_n           <= 1'b1;
            req                  <= 1'b0;
            arg_a                <= '0;
            arg_b                <= '0;
            arg_a_parity         <= 1'b0;
            arg_b_parity         <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_op               <= '0;
            rsp_result           <= '0;
            rsp_arg_err          <= 1'b0;
            rsp_arg_err_mismatch <= 1'b0;
            rsp_res_par_err      <= 1'b0;
            rsp_timeout          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op         <= cmd_op;
                        arg_a        <= cmd_a;
                        arg_b        <= cmd_b;
                        arg_a_parity <= (^cmd_a) ^ w_inv_a;
                        arg_b_parity <= (^cmd_b) ^ w_inv_b;
                        r_exp_err    <= w_inv_a | w_inv_b;
                        r_cnt        <= '0;
                        r_rst_cnt    <= '0;
                        if (cmd_op == RST_OP) begin
                            mult_rst_n <= 1'b0;
                            r_state    <= MRST;
                        end else begin
                            req     <= 1'b1;
                            r_state <= REQ;
                        end
                    end
                end
                MRST: begin
                    if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        mult_rst_n           <= 1'b1;
                        rsp_valid            <= 1'b1;
                        rsp_op               <= r_op;
                        rsp_result           <= '0;
                        rsp_arg_err          <= 1'b0;
                        rsp_arg_err_mismatch <= 1'b0;
                        rsp_res_par_err      <= 1'b0;
                        rsp_timeout          <= 1'b0;
                        r_state              <= RSP;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RC_W'(1);
                    end
                end
                REQ, WAIT_RES: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // result_rdy outranks both the timeout and a pending ack.
                    if (result_rdy) begin
                        req                  <= 1'b0;
                        rsp_valid            <= 1'b1;
                        rsp_op               <= r_op;
                        rsp_result           <= result;
                        rsp_arg_err          <= arg_parity_error;
                        rsp_arg_err_mismatch <= arg_parity_error ^ r_exp_err;
                        rsp_res_par_err      <= w_res_par_err;
                        rsp_timeout          <= 1'b0;
                        r_state              <= RSP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        req                  <= 1'b0;
                        rsp_valid            <= 1'b1;
                        rsp_op               <= r_op;
                        rsp_result           <= '0;
                        rsp_arg_err          <= 1'b0;
                        rsp_arg_err_mismatch <= 1'b0;
                        rsp_res_par_err      <= 1'b0;
                        rsp_timeout          <= 1'b1;
                        r_state              <= RSP;
                    end else if (r_state == REQ && ack) begin
                        req     <= 1'b0;
                        r_state <= WAIT_RES;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_cmd_driver.sv
// Scoreboard bench for mult_cmd_driver with a behavioural multiplier responder.
module tb_mult_cmd_driver;
    import mult_pkg::*;

    localparam int DW   = 16;
    localparam int TMO  = 8;
    localparam int RSTC = 2;

    logic          clk, rst_n, cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_a, cmd_b;
    logic          mult_rst_n, req;
    logic [DW-1:0] arg_a, arg_b;
    logic          arg_a_parity, arg_b_parity, ack;
    logic [2*DW-1:0] result;
    logic          result_parity, result_rdy, arg_parity_error;
    logic          rsp_valid, rsp_ready;
    logic [2:0]    rsp_op;
    logic [2*DW-1:0] rsp_result;
    logic          rsp_arg_err, rsp_arg_err_mismatch, rsp_res_par_err, rsp_timeout;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        logic        err, mism, rpe, tout;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // multiplier behaviour knobs, changed only while the DUT is idle
    int   m_delay       = 0;
    bit   m_silent      = 1'b0;
    bit   m_bad_par     = 1'b0;
    bit   m_force_noerr = 1'b0;
    bit   m_busy        = 1'b0;
    int   m_wait        = 0;
    logic [31:0] m_prod = '0;
    logic        m_perr = 1'b0;

    mult_cmd_driver #(.DATA_W(DW), .TIMEOUT(TMO), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .mult_rst_n(mult_rst_n),
        .req(req), .arg_a(arg_a), .arg_b(arg_b), .arg_a_parity(arg_a_parity),
        .arg_b_parity(arg_b_parity), .ack(ack), .result(result),
        .result_parity(result_parity), .result_rdy(result_rdy),
        .arg_parity_error(arg_parity_error), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_result(rsp_result),
        .rsp_arg_err(rsp_arg_err), .rsp_arg_err_mismatch(rsp_arg_err_mismatch),
        .rsp_res_par_err(rsp_res_par_err), .rsp_timeout(rsp_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Multiplier: acks the first req cycle, answers m_delay cycles later.
    always @(negedge clk) begin
        ack              = 1'b0;
        result_rdy       = 1'b0;
        arg_parity_error = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else begin
            if (req && !m_busy && !m_silent) begin
                ack    = 1'b1;
                m_busy = 1'b1;
                m_wait = 0;
                m_prod = {16'b0, arg_a} * {16'b0, arg_b};
                m_perr = (arg_a_parity != ^arg_a) || (arg_b_parity != ^arg_b);
            end
            if (m_busy) begin
                if (m_wait == m_delay) begin
                    result_rdy       = 1'b1;
                    result           = m_prod;
                    result_parity    = (^m_prod) ^ m_bad_par;
                    arg_parity_error = m_force_noerr ? 1'b0 : m_perr;
                    m_busy           = 1'b0;
                end else begin
                    m_wait++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit inv_a(input logic [2:0] op);
        return (op == 3'd2) || (op == 3'd4);
    endfunction

    function automatic bit inv_b(input logic [2:0] op);
        return (op == 3'd2) || (op == 3'd3);
    endfunction

    function automatic rsp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        rsp_t r;
        r.op = op; r.res = '0; r.err = 1'b0; r.mism = 1'b0; r.rpe = 1'b0; r.tout = 1'b0;
        if (op == 3'd0) return r;
        if (m_silent) begin
            r.tout = 1'b1;
            return r;
        end
        r.res  = {16'b0, a} * {16'b0, b};
        r.err  = m_force_noerr ? 1'b0 : (inv_a(op) | inv_b(op));
        r.mism = r.err ^ (op == 3'd2 || op == 3'd3 || op == 3'd4);
        r.rpe  = m_bad_par;
        return r;
    endfunction

    // Drives one command; returns in the first cycle after the accept edge.
    task automatic send_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        if (push) exp_q.push_back(model(op, a, b));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
        if (op == 3'd0) begin
            check("mrst_first", 64'(mult_rst_n), 64'(0));
            check("mrst_req", 64'(req), 64'(0));
        end else begin
            check("req_first", 64'(req), 64'(1));
            check("arg_a", 64'(arg_a), 64'(a));
            check("arg_b", 64'(arg_b), 64'(b));
            check("par_a", 64'(arg_a_parity), 64'((^a) ^ inv_a(op)));
            check("par_b", 64'(arg_b_parity), 64'((^b) ^ inv_b(op)));
        end
    endtask

    // Waits for a response, optionally stalls it, then compares with the scoreboard.
    task automatic collect(input int hold, output int lat, output int lows, output int reqs);
        rsp_t e;
        int n = 0;
        lows = 0;
        reqs = 0;
        while (!rsp_valid && n < 60) begin
            if (!mult_rst_n) lows++;
            if (req) reqs++;
            @(negedge clk);
            n++;
        end
        lat = n + 1;
        check("rsp_seen", 64'(rsp_valid), 64'(1));
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
        if (!rsp_valid || exp_q.size() == 0) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        check("req_low_at_rsp", 64'(req), 64'(0));
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_result", 64'(rsp_result), 64'(e.res));
            check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
            @(negedge clk);
        end
        check("rsp_op", 64'(rsp_op), 64'(e.op));
        check("rsp_result", 64'(rsp_result), 64'(e.res));
        check("rsp_arg_err", 64'(rsp_arg_err), 64'(e.err));
        check("rsp_mismatch", 64'(rsp_arg_err_mismatch), 64'(e.mism));
        check("rsp_res_par_err", 64'(rsp_res_par_err), 64'(e.rpe));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.tout));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 64'(rsp_valid), 64'(0));
        check("cmd_ready_after", 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        int lat, lows, reqs, cnt;
        logic [2:0] op;
        logic [15:0] a, b;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_mult_rst_n", 64'(mult_rst_n), 64'(1));
        check("rst_req", 64'(req), 64'(0));
        check("rst_args", 64'({arg_a, arg_b, arg_a_parity, arg_b_parity}), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp", 64'({rsp_op, rsp_result, rsp_arg_err, rsp_arg_err_mismatch,
                              rsp_res_par_err, rsp_timeout}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // minimum latency path: ack and result_rdy in the first REQ cycle
        send_cmd(3'd1, 16'd3, 16'd5, 1'b1);
        collect(0, lat, lows, reqs);
        check("min_latency", 64'(lat), 64'(2));

        send_cmd(3'd2, 16'h0001, 16'h0003, 1'b1);
        collect(0, lat, lows, reqs);
        m_force_noerr = 1'b1;
        send_cmd(3'd2, 16'h0001, 16'h0003, 1'b1);
        collect(0, lat, lows, reqs);
        m_force_noerr = 1'b0;

        m_delay = 2;
        send_cmd(3'd3, 16'h1234, 16'h00F1, 1'b1);
        collect(0, lat, lows, reqs);
        send_cmd(3'd4, 16'hA5A5, 16'h0102, 1'b1);
        collect(0, lat, lows, reqs);
        check("lat_delay2", 64'(lat), 64'(4));
        m_delay = 0;

        send_cmd(3'd0, 16'h0000, 16'h0000, 1'b1);
        collect(0, lat, lows, reqs);
        check("mrst_low_cycles", 64'(lows), 64'(RSTC));
        check("mrst_req_cycles", 64'(reqs), 64'(0));
        check("mrst_latency", 64'(lat), 64'(RSTC + 1));
        check("mrst_released", 64'(mult_rst_n), 64'(1));

        m_silent = 1'b1;
        send_cmd(3'd1, 16'd7, 16'd9, 1'b1);
        collect(0, lat, lows, reqs);
        check("tmo_req_cycles", 64'(reqs), 64'(TMO));
        check("tmo_latency", 64'(lat), 64'(TMO + 1));
        check("tmo_req_low", 64'(req), 64'(0));
        m_silent = 1'b0;

        send_cmd(3'd1, 16'hFFFF, 16'hFFFF, 1'b1);
        collect(0, lat, lows, reqs);

        m_bad_par = 1'b1;
        send_cmd(3'd1, 16'd3, 16'd5, 1'b1);
        collect(5, lat, lows, reqs);
        m_bad_par = 1'b0;

        send_cmd(3'd5, 16'h0F0F, 16'h0033, 1'b1);
        collect(0, lat, lows, reqs);

        for (int i = 0; i < 8; i++) begin
            op            = 3'($urandom_range(1, 4));
            a             = 16'($urandom);
            b             = 16'($urandom);
            m_delay       = $urandom_range(0, 3);
            m_force_noerr = 1'($urandom_range(0, 1));
            send_cmd(op, a, b, 1'b1);
            collect(int'($urandom_range(0, 2)), lat, lows, reqs);
        end
        m_force_noerr = 1'b0;

        // reset while waiting for the result: command vanishes without a response
        m_delay = 5;
        send_cmd(3'd1, 16'd11, 16'd13, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_req", 64'(req), 64'(0));
        check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        check("abort_rsp_result", 64'(rsp_result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("abort_no_rsp", 64'(cnt), 64'(0));
        check("abort_sb_empty", 64'(exp_q.size()), 64'(0));

        m_delay = 1;
        send_cmd(3'd1, 16'd200, 16'd300, 1'b1);
        collect(0, lat, lows, reqs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
